softmax_seq_ctrl: RTL
=====================

# softmax_seq_ctrl

Parametrised stage sequencer for the softmax datapath. It runs the four softmax stages in order for each of N rows in a batch: sort/max, exp(Xmax−Xi) with accumulate F, lnF, and exp(Xmax−Xi−lnF). Stage lengths are parameters, and the block adds a start/done handshake, a row loop, stall and abort. It sits between the top-level accelerator control and the softmax datapath, which consumes its stage flags, `sort_en` and `row_idx`.

## Interface
- `S1_LEN`, 12: STAGE1 (sort/max) length in cycles, ≥1
- `S2_LEN`, 2: STAGE2 (exp, accumulate F) length, ≥1
- `S3_LEN`, 4: STAGE3 (lnF) length, ≥1
- `S4_LEN`, 7: STAGE4 (final exp) length, ≥1
- `CNT_W`, 8: stage counter width; must hold max(S*_LEN)−1
- `ROW_W`, 8: row count/index width
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `start` in 1: begin batch; sampled only when `busy`=0
- `num_rows` in ROW_W: rows in batch, latched on accepted `start`; 0 is treated as 1
- `stall` in 1: freeze sequencer (datapath back-pressure)
- `abort` in 1: synchronous cancel, highest priority
- `busy` out 1: batch in progress
- `is_stage1`..`is_stage4` out 1 each: one-hot stage flags
- `sort_en` out 1: sorter enable, equal to `is_stage1`
- `stage_first` out 1: high on the first cycle of any stage
- `row_idx` out ROW_W: current row, 0-based
- `row_done` out 1: 1-cycle pulse per completed row
- `done` out 1: 1-cycle pulse at batch completion

## Operation
- FSM states: IDLE, STAGE1, STAGE2, STAGE3, STAGE4. All outputs are registered.
- IDLE → STAGE1 on `start` when not `abort`.
  - Latch rows = max(`num_rows`,1).
  - Set `row_idx`=0 and stage counter `cnt`=0.
- STAGEk: `cnt` increments each non-stalled cycle. When `cnt`==Sk_LEN−1 and `stall`=0, move to STAGEk+1 and reset `cnt` to 0.
- Leaving STAGE4:
  - If `row_idx`==rows−1: go to IDLE.
  - Otherwise: go to STAGE1 with `row_idx`+1.
- `stall`=1 holds state, `cnt`, `row_idx` and all stage flags. `stage_first` drops after the first cycle even if stalled there. `stall` has no effect in IDLE.
- `abort`=1 in any state: go to IDLE next cycle. All flags clear, `row_done` and `done` are not pulsed. Abort overrides `stall` and `start`.
- `start` while `busy`=1 is ignored, and `num_rows` is not re-latched.
- `is_stageN`, `sort_en` and `busy` are direct decodes of the registered state. `busy` = state≠IDLE.

## Timing
- Reset (`rst`=0, async):
  - state=IDLE, `cnt`=0, `row_idx`=0.
  - `busy`, all `is_stage`, `sort_en`, `stage_first`, `row_done` and `done` = 0.
- Reset release takes effect on the next rising edge. Reset mid-batch drops every output to 0 immediately and produces no `done`.
- Row time is L = S1_LEN+S2_LEN+S3_LEN+S4_LEN cycles (25 with defaults) with no stalls.
- `start` sampled at edge 0 (defaults):
  - `is_stage1` = cycles 1–12
  - `is_stage2` = cycles 13–14
  - `is_stage3` = cycles 15–18
  - `is_stage4` = cycles 19–25
- `row_done` pulses in the cycle after the last STAGE4 cycle.
  - Multi-row: this coincides with the next row's first STAGE1 cycle, and `row_idx` has already incremented.
  - Last row: `done` pulses in the same cycle and `busy`=0.
- Back-to-back batches: a `start` in the `done` cycle is accepted, and STAGE1 begins the following cycle.
- Each stall cycle extends the current stage by exactly one cycle.
- `stage_first`=1 on cycles 1, 13, 15 and 19, and on every row's first STAGE1 cycle.

## Test plan
- **Single row, defaults:** reset, then `start`=1 for one cycle with `num_rows`=1.
  - Stage windows are exactly 1–12, 13–14, 15–18, 19–25, with `sort_en` matching `is_stage1`.
  - `row_done`=`done`=1 at cycle 26, `busy` high for cycles 1–25 only.
- **Multi-row:** `num_rows`=3.
  - `row_idx` steps 0→1→2 at cycles 26 and 51.
  - `row_done` pulses at 26, 51 and 76; `done` pulses only at 76.
  - `num_rows`=0 behaves exactly like 1.
- **Stall:**
  - `stall`=1 for 3 cycles during cycles 14–16: STAGE2 holds, STAGE3 starts at cycle 18, `done` at 29.
  - `stall` in IDLE has no effect.
- **Abort:**
  - `abort` at cycle 16: all flags are 0 from cycle 17, no `done`.
  - A new `start` at cycle 17 restarts STAGE1 at cycle 18 with `row_idx`=0.
- **Start while busy / back-to-back:**
  - `start` at cycle 5 is ignored: timing is unchanged and `num_rows` is not re-latched.
  - `start` at cycle 26 gives STAGE1 from cycle 27.
- **Reset mid-operation and parameter sweep:**
  - Assert `rst`=0 asynchronously at cycle 10: all outputs are 0 immediately.
  - Rerun the first scenario with S1..S4 = 1,1,1,1: stages last 1 cycle each, `done` at cycle 5.

Source files
------------

// File: rtl/softmax_seq_ctrl.sv
// Stage sequencer for the softmax datapath: walks sort/max, exp+accumulate,
// lnF and final exp for every row of a batch, with stall and abort.
module softmax_seq_ctrl #(
  parameter int S1_LEN = 12,
  parameter int S2_LEN = 2,
  parameter int S3_LEN = 4,
  parameter int S4_LEN = 7,
  parameter int CNT_W  = 8,
  parameter int ROW_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ROW_W-1:0] num_rows,
  input  logic             stall,
  input  logic             abort,
  output logic             busy,
  output logic             is_stage1,
  output logic             is_stage2,
  output logic             is_stage3,
  output logic             is_stage4,
  output logic             sort_en,
  output logic             stage_first,
  output logic [ROW_W-1:0] row_idx,
  output logic             row_done,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STAGE1 = 3'd1,
    STAGE2 = 3'd2,
    STAGE3 = 3'd3,
    STAGE4 = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [ROW_W-1:0] last_row;
  logic             stage_end;

  function automatic logic [CNT_W-1:0] stage_last(input state_t s);
    logic [CNT_W-1:0] r;
    case (s)
      STAGE1:  r = CNT_W'(S1_LEN - 1);
      STAGE2:  r = CNT_W'(S2_LEN - 1);
      STAGE3:  r = CNT_W'(S3_LEN - 1);
      STAGE4:  r = CNT_W'(S4_LEN - 1);
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic state_t next_stage(input state_t s);
    state_t r;
    case (s)
      STAGE1:  r = STAGE2;
      STAGE2:  r = STAGE3;
      STAGE3:  r = STAGE4;
      default: r = IDLE;
    endcase
    return r;
  endfunction

  always_comb begin
    stage_end = (cnt == stage_last(state));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      row_idx     <= '0;
      last_row    <= '0;
      stage_first <= 1'b0;
      row_done    <= 1'b0;
      done        <= 1'b0;
    end else begin
      stage_first <= 1'b0;
      row_done    <= 1'b0;
      done        <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        cnt     <= '0;
        row_idx <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state       <= STAGE1;
              cnt         <= '0;
              row_idx     <= '0;
              // A zero row count runs a single row.
              last_row    <= (num_rows == '0) ? '0 : num_rows - ROW_W'(1);
              stage_first <= 1'b1;
            end
          end
          STAGE1, STAGE2, STAGE3: begin
            if (!stall) begin
              if (stage_end) begin
                state       <= next_stage(state);
                cnt         <= '0;
                stage_first <= 1'b1;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          STAGE4: begin
            if (!stall) begin
              if (stage_end) begin
                cnt      <= '0;
                row_done <= 1'b1;
                if (row_idx == last_row) begin
                  state   <= IDLE;
                  row_idx <= '0;
                  done    <= 1'b1;
                end else begin
                  state       <= STAGE1;
                  row_idx     <= row_idx + ROW_W'(1);
                  stage_first <= 1'b1;
                end
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign busy      = (state != IDLE);
  assign is_stage1 = (state == STAGE1);
  assign is_stage2 = (state == STAGE2);
  assign is_stage3 = (state == STAGE3);
  assign is_stage4 = (state == STAGE4);
  assign sort_en   = (state == STAGE1);

endmodule
